// File: rtl/gpu_ucode_seq_if.sv
// Sequencer bus: store write port, micro-op valid/ready issue channel, control and status.
// The master modport is the host/execution side; the slave modport is the sequencer.
interface gpu_ucode_seq_if #(
    parameter int ADDR_W = 8,
    parameter int UOP_W  = 20
);
    logic              enable;
    logic              zero;
    logic              sync;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [UOP_W+3:0]  wr_dat;
    logic [UOP_W-1:0]  uop_dat;
    logic              uop_vld;
    logic              uop_rdy;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              stack_err;

    modport master (
        output enable, zero, sync, wr_en, wr_addr, wr_dat, uop_rdy,
        input  uop_dat, uop_vld, pc, halted, stack_err
    );

    modport slave (
        input  enable, zero, sync, wr_en, wr_addr, wr_dat, uop_rdy,
        output uop_dat, uop_vld, pc, halted, stack_err
    );
endinterface

// File: rtl/gpu_ucode_seq.sv
// Microcode sequencer: one word resolved per slot-free RUN cycle, issued micro-op registered (1 cycle).
// Backpressure: a held micro-op stalls PC and state until uop_rdy; control ops leave a one-cycle bubble.
module gpu_ucode_seq #(
    parameter int ADDR_W      = 8,
    parameter int UOP_W       = 20,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 1
) (
    input  logic clk,
    input  logic rst_n,
    gpu_ucode_seq_if.slave bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [3:0] OP_GOTO = 4'd1;
    localparam logic [3:0] OP_JZ   = 4'd2;
    localparam logic [3:0] OP_JNZ  = 4'd3;
    localparam logic [3:0] OP_CALL = 4'd4;
    localparam logic [3:0] OP_RET  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;
    localparam logic [3:0] OP_WAIT = 4'd7;

    typedef struct packed {
        logic [3:0]       seq;
        logic [UOP_W-1:0] payload;
    } uword_t;

    uword_t            mem [2**ADDR_W];
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic [UOP_W-1:0]  uop;
    logic              uop_vld;
    logic              stack_err;

    uword_t            word;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              slot_free;
    logic              accepted;

    // Store is never reset; the registered resolution sees the pre-write word.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_dat;
        end
    end

    assign word      = mem[pc];
    assign target    = word.payload[ADDR_W-1:0];
    assign pc_inc    = pc + ADDR_W'(1);
    assign push_idx  = IDX_W'(sp);
    assign pop_idx   = IDX_W'(sp - SP_W'(1));
    assign accepted  = uop_vld && bus.uop_rdy;
    assign slot_free = !uop_vld || bus.uop_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= START_PC;
            sp        <= '0;
            uop       <= '0;
            uop_vld   <= 1'b0;
            stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (!bus.enable) begin
            state   <= S_IDLE;
            uop_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_RUN;
                    pc        <= START_PC;
                    sp        <= '0;
                    stack_err <= 1'b0;
                end
                S_RUN: begin
                    if (slot_free) begin
                        // Control ops issue nothing, so an accepted slot leaves a bubble.
                        uop_vld <= 1'b0;
                        case (word.seq)
                            OP_GOTO: pc <= target;
                            OP_JZ:   pc <= bus.zero ? target : pc_inc;
                            OP_JNZ:  pc <= bus.zero ? pc_inc : target;
                            OP_CALL: begin
                                if (sp == SP_FULL) begin
                                    stack_err <= 1'b1;
                                    state     <= S_HALT;
                                end else begin
                                    stack[push_idx] <= pc_inc;
                                    sp              <= sp + SP_W'(1);
                                    pc              <= target;
                                end
                            end
                            OP_RET: begin
                                if (sp == '0) begin
                                    stack_err <= 1'b1;
                                    state     <= S_HALT;
                                end else begin
                                    pc <= stack[pop_idx];
                                    sp <= sp - SP_W'(1);
                                end
                            end
                            OP_HALT: begin
                                state <= S_HALT;
                                pc    <= pc_inc;
                            end
                            OP_WAIT: begin
                                state <= S_WAIT;
                                pc    <= pc_inc;
                            end
                            default: begin
                                uop     <= word.payload;
                                uop_vld <= 1'b1;
                                pc      <= pc_inc;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (accepted) begin
                        uop_vld <= 1'b0;
                    end
                    if (bus.sync) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    if (accepted) begin
                        uop_vld <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.uop_dat   = uop;
    assign bus.uop_vld   = uop_vld;
    assign bus.pc        = pc;
    assign bus.halted    = (state == S_HALT);
    assign bus.stack_err = stack_err;
endmodule

// File: tb/tb_gpu_ucode_seq.sv
// Directed bench for gpu_ucode_seq: two instances (START_ADDR 1 and 255) sharing clock and reset.
module tb_gpu_ucode_seq;
    localparam logic [3:0] NEXT = 4'd0, GOTO = 4'd1, JZ = 4'd2, CALL = 4'd4,
                           RET = 4'd5, HALT = 4'd6, WSYNC = 4'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    gpu_ucode_seq_if #(.ADDR_W(8), .UOP_W(20)) bus_a ();
    gpu_ucode_seq_if #(.ADDR_W(8), .UOP_W(20)) bus_b ();

    gpu_ucode_seq #(.ADDR_W(8), .UOP_W(20), .STACK_DEPTH(4), .START_ADDR(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    gpu_ucode_seq #(.ADDR_W(8), .UOP_W(20), .STACK_DEPTH(4), .START_ADDR(255))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    function automatic logic [23:0] mk(input logic [3:0] s, input logic [19:0] p);
        return {s, p};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input bit sel_b, input string tag, input logic exp_vld,
                           input logic [19:0] exp_uop, input logic [7:0] exp_pc);
        logic        got_vld;
        logic [19:0] got_uop;
        logic [7:0]  got_pc;
        got_vld = sel_b ? bus_b.uop_vld : bus_a.uop_vld;
        got_uop = sel_b ? bus_b.uop_dat : bus_a.uop_dat;
        got_pc  = sel_b ? bus_b.pc      : bus_a.pc;
        check({tag, ".vld"}, 32'(got_vld), 32'(exp_vld));
        if (exp_vld) check({tag, ".uop"}, 32'(got_uop), 32'(exp_uop));
        check({tag, ".pc"}, 32'(got_pc), 32'(exp_pc));
    endtask

    task automatic chk_flags(input bit sel_b, input string tag, input logic exp_halt,
                             input logic exp_err);
        check({tag, ".halted"}, 32'(sel_b ? bus_b.halted : bus_a.halted), 32'(exp_halt));
        check({tag, ".err"}, 32'(sel_b ? bus_b.stack_err : bus_a.stack_err), 32'(exp_err));
    endtask

    task automatic wr(input bit sel_b, input logic [7:0] a, input logic [23:0] d);
        if (sel_b) begin
            bus_b.wr_en = 1'b1; bus_b.wr_addr = a; bus_b.wr_dat = d;
        end else begin
            bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_dat = d;
        end
        step();
        bus_a.wr_en = 1'b0;
        bus_b.wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.enable = 0; bus_a.zero = 0; bus_a.sync = 0; bus_a.wr_en = 0;
        bus_a.wr_addr = '0; bus_a.wr_dat = '0; bus_a.uop_rdy = 0;
        bus_b.enable = 0; bus_b.zero = 0; bus_b.sync = 0; bus_b.wr_en = 0;
        bus_b.wr_addr = '0; bus_b.wr_dat = '0; bus_b.uop_rdy = 0;
        step();

        // Reset state
        chk_out(0, "rst_a", 1'b0, 20'h0, 8'd1);
        check("rst_a.uop", 32'(bus_a.uop_dat), 32'h0);
        chk_flags(0, "rst_a", 1'b0, 1'b0);
        chk_out(1, "rst_b", 1'b0, 20'h0, 8'd255);

        // Stores load while in reset
        wr(1, 8'd255, mk(NEXT, 20'hF));
        wr(1, 8'd0,   mk(WSYNC, 20'h0));
        wr(1, 8'd1,   mk(NEXT, 20'h1));
        wr(1, 8'd2,   mk(HALT, 20'h0));
        wr(0, 8'd1,   mk(NEXT, 20'hAAA));
        wr(0, 8'd2,   mk(NEXT, 20'hBBB));
        wr(0, 8'd3,   mk(GOTO, 20'd1));
        rst_n = 1'b1;

        // NEXT/NEXT/GOTO loop with a same-cycle overwrite of the word being resolved
        bus_a.uop_rdy = 1; bus_a.enable = 1;
        step(); chk_out(0, "loop_e1", 1'b0, 20'h0,   8'd1);
        step(); chk_out(0, "loop_e2", 1'b1, 20'hAAA, 8'd2);
        step(); chk_out(0, "loop_e3", 1'b1, 20'hBBB, 8'd3);
        step(); chk_out(0, "loop_e4", 1'b0, 20'h0,   8'd1);
        step(); chk_out(0, "loop_e5", 1'b1, 20'hAAA, 8'd2);
        wr(0, 8'd2, mk(NEXT, 20'hCCC));
        chk_out(0, "wr_same", 1'b1, 20'hBBB, 8'd3);
        step(); chk_out(0, "loop_e7", 1'b0, 20'h0,   8'd1);
        step(); chk_out(0, "loop_e8", 1'b1, 20'hAAA, 8'd2);
        step(); chk_out(0, "wr_new",  1'b1, 20'hCCC, 8'd3);
        bus_a.enable = 0;
        step(); chk_out(0, "flush", 1'b0, 20'h0, 8'd3);

        // Backpressure hold
        wr(0, 8'd1, mk(NEXT, 20'h111));
        wr(0, 8'd2, mk(NEXT, 20'h222));
        bus_a.uop_rdy = 0; bus_a.enable = 1;
        step(); chk_out(0, "bp_e1", 1'b0, 20'h0, 8'd1);
        step(); chk_out(0, "bp_e2", 1'b1, 20'h111, 8'd2);
        for (int i = 0; i < 5; i++) begin
            step(); chk_out(0, "bp_hold", 1'b1, 20'h111, 8'd2);
        end
        bus_a.uop_rdy = 1;
        step(); chk_out(0, "bp_rel", 1'b1, 20'h222, 8'd3);
        bus_a.uop_rdy = 0; bus_a.enable = 0;
        step();

        // JZ taken / not taken
        wr(0, 8'd1, mk(JZ, 20'd5));
        wr(0, 8'd2, mk(NEXT, 20'h2));
        wr(0, 8'd3, mk(HALT, 20'h0));
        wr(0, 8'd5, mk(NEXT, 20'h5));
        wr(0, 8'd6, mk(HALT, 20'h0));
        bus_a.uop_rdy = 1; bus_a.zero = 1; bus_a.enable = 1;
        step(); step(); chk_out(0, "jz1_jump", 1'b0, 20'h0, 8'd5);
        step(); chk_out(0, "jz1_iss", 1'b1, 20'h5, 8'd6);
        step(); chk_out(0, "jz1_halt", 1'b0, 20'h0, 8'd7);
        chk_flags(0, "jz1_halt", 1'b1, 1'b0);
        bus_a.enable = 0; bus_a.zero = 0;
        step(); chk_flags(0, "jz_idle", 1'b0, 1'b0);
        bus_a.enable = 1;
        step(); step(); chk_out(0, "jz0_fall", 1'b0, 20'h0, 8'd2);
        step(); chk_out(0, "jz0_iss", 1'b1, 20'h2, 8'd3);
        step(); chk_out(0, "jz0_halt", 1'b0, 20'h0, 8'd4);
        bus_a.enable = 0;
        step();

        // Nested CALLs past the stack depth
        wr(0, 8'd1,  mk(CALL, 20'd10));
        wr(0, 8'd10, mk(CALL, 20'd20));
        wr(0, 8'd20, mk(CALL, 20'd30));
        wr(0, 8'd30, mk(CALL, 20'd40));
        wr(0, 8'd40, mk(CALL, 20'd50));
        bus_a.enable = 1;
        repeat (5) step();
        chk_out(0, "call4", 1'b0, 20'h0, 8'd40);
        chk_flags(0, "call4", 1'b0, 1'b0);
        step(); chk_out(0, "call5", 1'b0, 20'h0, 8'd40);
        chk_flags(0, "call5", 1'b1, 1'b1);
        step(); chk_out(0, "halt_stay", 1'b0, 20'h0, 8'd40);
        chk_flags(0, "halt_stay", 1'b1, 1'b1);
        bus_a.enable = 0;
        step(); chk_flags(0, "err_sticky", 1'b0, 1'b1);

        // Matched CALL/RET returns to caller+1
        wr(0, 8'd40, mk(RET, 20'h0));
        wr(0, 8'd31, mk(NEXT, 20'h31));
        wr(0, 8'd32, mk(HALT, 20'h0));
        bus_a.enable = 1;
        step(); chk_flags(0, "err_clr", 1'b0, 1'b0);
        repeat (4) step();
        step(); chk_out(0, "ret_pc", 1'b0, 20'h0, 8'd31);
        step(); chk_out(0, "ret_iss", 1'b1, 20'h31, 8'd32);
        bus_a.enable = 0;
        step();

        // RET with an empty stack
        wr(0, 8'd1, mk(RET, 20'h0));
        bus_a.enable = 1;
        step(); step(); chk_out(0, "ret_empty", 1'b0, 20'h0, 8'd1);
        chk_flags(0, "ret_empty", 1'b1, 1'b1);
        bus_a.enable = 0;
        step();

        // WAITSYNC at the wrap point, sync in the resolving cycle ignored
        bus_b.uop_rdy = 1; bus_b.enable = 1;
        step(); chk_out(1, "ws_e1", 1'b0, 20'h0, 8'd255);
        step(); chk_out(1, "ws_wrap", 1'b1, 20'hF, 8'd0);
        bus_b.sync = 1;
        step(); chk_out(1, "ws_enter", 1'b0, 20'h0, 8'd1);
        chk_flags(1, "ws_enter", 1'b0, 1'b0);
        bus_b.sync = 0;
        step(); chk_out(1, "ws_hold1", 1'b0, 20'h0, 8'd1);
        step(); chk_out(1, "ws_hold2", 1'b0, 20'h0, 8'd1);
        bus_b.sync = 1;
        step(); chk_out(1, "ws_rel", 1'b0, 20'h0, 8'd1);
        bus_b.sync = 0;
        step(); chk_out(1, "ws_iss", 1'b1, 20'h1, 8'd2);
        bus_b.enable = 0;
        step();

        // Asynchronous reset mid-operation
        wr(0, 8'd1, mk(NEXT, 20'h123));
        bus_a.uop_rdy = 0; bus_a.enable = 1;
        step(); step(); chk_out(0, "ar_pre", 1'b1, 20'h123, 8'd2);
        #2 rst_n = 1'b0;
        #1 chk_out(0, "ar_now", 1'b0, 20'h0, 8'd1);
        check("ar_now.uop", 32'(bus_a.uop_dat), 32'h0);
        #1 rst_n = 1'b1;
        step(); chk_out(0, "ar_run", 1'b0, 20'h0, 8'd1);
        step(); chk_out(0, "ar_store", 1'b1, 20'h123, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_ucode_seq.md
GPU_UCODE_SEQ -- requirements
Module: gpu_ucode_seq

Interface
REQ-001 Parameter ADDR_W, default 8: microcode address width; the store holds 2^ADDR_W words.
REQ-002 Parameter UOP_W, default 20: payload width of one micro-op.
REQ-003 Parameter STACK_DEPTH, default 4: call-stack entries, minimum 1.
REQ-004 Parameter START_ADDR, default 1: PC loaded when entering RUN from IDLE.
REQ-005 iClock  in  1  single clock; all state changes on its rising edge.
REQ-006 iReset_n  in  1  asynchronous, active-low reset.
REQ-007 iEnable  in  1  high = sequencer may run; low = return to IDLE.
REQ-008 iZero  in  1  zero flag from the execution unit, sampled when a JZ/JNZ resolves.
REQ-009 iSync  in  1  single-cycle frame/line sync pulse, releases WAITSYNC.
REQ-010 iWrEn  in  1  store write strobe.
REQ-011 iWrAddr  in  ADDR_W  store write address.
REQ-012 iWrData  in  UOP_W+4  store word: [UOP_W+3:UOP_W] = seq field, [UOP_W-1:0] = payload.
REQ-013 oUop  out  UOP_W  issued micro-op payload, registered.
REQ-014 oUopValid  out  1  oUop holds an unaccepted micro-op.
REQ-015 iUopReady  in  1  execution unit accepts oUop when oUopValid and iUopReady are both high.
REQ-016 oPc  out  ADDR_W  current fetch address.
REQ-017 oHalted  out  1  high in HALT state.
REQ-018 oStackErr  out  1  sticky stack overflow/underflow flag.

Function
REQ-019 The store SHALL be a 2^ADDR_W x (UOP_W+4) array with a synchronous write port and an asynchronous read at oPc; it SHALL NOT be reset.
REQ-020 Seq field codes: 0 NEXT, 1 GOTO, 2 JZ, 3 JNZ, 4 CALL, 5 RET, 6 HALT, 7 WAITSYNC; codes 8-15 SHALL behave as NEXT. The jump target SHALL be payload[ADDR_W-1:0].
REQ-021 States: IDLE, RUN, WAIT, HALT.
REQ-022 IDLE -> RUN when iEnable=1: PC=START_ADDR, stack pointer=0.
REQ-023 In any state, iEnable=0 SHALL force IDLE on the next edge and clear oUopValid (flush).
REQ-024 "Slot free" means oUopValid=0, or oUopValid=1 and iUopReady=1.
- In RUN, the word at PC SHALL resolve only in a slot-free cycle.
- Otherwise PC, state and oUop SHALL hold.
REQ-025 NEXT resolution: oUop<=payload, oUopValid<=1, PC<=PC+1.
REQ-026 Control-op resolution (GOTO, JZ, JNZ, CALL, RET, HALT, WAITSYNC): the payload SHALL NOT be issued, and oUopValid<=0 if the slot was accepted that cycle (one-cycle bubble per control op).
REQ-027 Jumps:
- GOTO: PC<=target.
- JZ: PC<=target if iZero=1, else PC+1.
- JNZ: PC<=target if iZero=0, else PC+1.
REQ-028 CALL: push PC+1, then PC<=target. RET: pop into PC.
REQ-029 CALL with stack full, or RET with stack empty: oStackErr<=1, state<=HALT, PC and stack unchanged.
REQ-030 HALT op: state<=HALT, PC<=PC+1. HALT is left only through IDLE (iEnable=0) or reset.
REQ-031 WAITSYNC: state<=WAIT, PC<=PC+1.
- WAIT -> RUN on the first iSync=1 in a later cycle.
- An iSync in the resolving cycle itself SHALL be ignored.
REQ-032 All PC arithmetic SHALL be modulo 2^ADDR_W: PC+1 from all-ones wraps to 0; a pushed return address wraps the same way.
REQ-033 Writes SHALL be accepted in every state. A write to the address being read in the same cycle SHALL NOT affect that cycle's resolution; the new word is visible from the next cycle.
REQ-034 An accepted micro-op SHALL NOT be repeated; a held micro-op SHALL NOT change while oUopValid=1 and iUopReady=0.
REQ-035 In HALT and WAIT, a pending oUop SHALL still be deliverable via handshake.
REQ-036 oStackErr SHALL clear only on reset or on the IDLE -> RUN transition.
REQ-037 oPc SHALL equal the internal PC; oHalted SHALL be high exactly in HALT.

Reset
REQ-038 iReset_n=0 SHALL immediately, without a clock edge, force:
- state=IDLE, PC=START_ADDR, stack pointer=0;
- oUop=0, oUopValid=0, oHalted=0, oStackErr=0.
Store contents are kept.
REQ-039 Reset asserted mid-operation SHALL discard any pending oUop and stack contents.

Verification
REQ-040 Load 1:NEXT 0x00AAA, 2:NEXT 0x00BBB, 3:GOTO 1; iEnable=1, iUopReady=1 -> oUop sequence AAA, BBB, bubble, AAA... with oPc 1,2,3,1.
REQ-041 Load 1:NEXT 0x00111; hold iUopReady=0 for 5 cycles -> oUop=0x00111 stable, oPc=2 held; ready=1 -> single acceptance, then the next word resolves.
REQ-042 Load 1:JZ 5, 2:NEXT 0x2, 5:NEXT 0x5; run with iZero=1 -> issues 0x5; rerun with iZero=0 -> issues 0x2.
REQ-043 STACK_DEPTH=4: nested CALLs 5 deep -> after the 4th CALL, the 5th sets oStackErr=1 and oHalted=1 with oPc at the 5th CALL; RET at an empty stack produces the same result.
REQ-044 Load 255:NEXT 0xF, 0:WAITSYNC, 1:NEXT 0x1, START_ADDR=255 -> 0xF issued, oPc wraps to 0, enters WAIT; iSync pulse on the resolving cycle ignored; later iSync -> 0x1 issued.
REQ-045 Assert iReset_n=0 between clock edges while oUopValid=1 -> oUopValid=0 and oPc=START_ADDR immediately, with store contents intact.
